// File: rtl/flit_avalon_pkg.sv
// +--------------------------------------------------------------------------+
// | flit_avalon_pkg : slave register map, status bits and FSM state encoding  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package flit_avalon_pkg;

  localparam logic [2:0] c_addr_status = 3'd0;
  localparam logic [2:0] c_addr_put    = 3'd1;
  localparam logic [2:0] c_addr_get    = 3'd2;

  localparam int c_stat_put_rdy = 0;
  localparam int c_stat_get_rdy = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POLL  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// +--------------------------------------------------------------------------+
// | flit_fifo : synchronous FIFO, head word is zero while empty               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module flit_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;
  logic             w_empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/flit_avalon_master.sv
// +--------------------------------------------------------------------------+
// | flit_avalon_master : Avalon-MM master moving flits between local FIFOs   |
// | and a polled flit slave.  Revision: 1.0                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module flit_avalon_master
  import flit_avalon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [2:0]  address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        irq,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] flits_sent,
  output logic [15:0] flits_rcvd
);

  state_t      r_state;
  logic [2:0]  r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [15:0] r_flits_sent;
  logic [15:0] r_flits_rcvd;

  logic [31:0] w_tx_head;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_tx_push;
  logic        w_rx_pop;
  logic        w_tx_pop;
  logic        w_rx_push;

  assign w_tx_push = tx_valid && !w_tx_full;
  assign w_rx_pop  = !w_rx_empty && rx_ready;
  assign w_tx_pop  = (r_state == ST_WRITE);
  assign w_rx_push = (r_state == ST_READ);

  flit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_tx_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .i_push      (w_tx_push),
    .i_push_data (tx_data),
    .i_pop       (w_tx_pop),
    .o_head      (w_tx_head),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty)
  );

  flit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_rx_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .i_push      (w_rx_push),
    .i_push_data (readdata),
    .i_pop       (w_rx_pop),
    .o_head      (rx_data),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty)
  );

  // Bus strobes are registered with the state they belong to, so they never
  // depend combinationally on readdata or irq.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_address    <= c_addr_status;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_flits_sent <= '0;
      r_flits_rcvd <= '0;
    end else begin
      r_address   <= c_addr_status;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_writedata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (irq || !w_tx_empty) begin
            r_state <= ST_POLL;
            r_read  <= 1'b1;
          end
        end
        ST_POLL: begin
          if (readdata[c_stat_get_rdy] && !w_rx_full) begin
            r_state   <= ST_READ;
            r_read    <= 1'b1;
            r_address <= c_addr_get;
          end else if (readdata[c_stat_put_rdy] && !w_tx_empty) begin
            // TX head is stable until the WRITE pop, so it can be latched now.
            r_state     <= ST_WRITE;
            r_write     <= 1'b1;
            r_address   <= c_addr_put;
            r_writedata <= w_tx_head;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_flits_rcvd <= r_flits_rcvd + 16'd1;
          r_state      <= ST_POLL;
          r_read       <= 1'b1;
        end
        ST_WRITE: begin
          r_flits_sent <= r_flits_sent + 16'd1;
          r_state      <= ST_POLL;
          r_read       <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign tx_ready   = !w_tx_full;
  assign rx_valid   = !w_rx_empty;
  assign flits_sent = r_flits_sent;
  assign flits_rcvd = r_flits_rcvd;

endmodule

`default_nettype wire

// File: tb/tb_flit_avalon_master.sv
// +--------------------------------------------------------------------------+
// | tb_flit_avalon_master : directed bench with a zero-latency flit slave    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_flit_avalon_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] flits_sent;
  logic [15:0] flits_rcvd;

  // Slave model state
  logic        put_ready = 1'b0;
  logic [7:0]  rx_total  = 8'd0;
  logic [7:0]  rx_taken  = 8'd0;
  logic [31:0] rx_vals [16];
  logic [31:0] wlog [16];
  int          wr_count  = 0;
  logic        w_get_rdy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  flit_avalon_master #(.FIFO_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .flits_sent (flits_sent),
    .flits_rcvd (flits_rcvd)
  );

  assign w_get_rdy = (rx_total != rx_taken);
  assign irq       = w_get_rdy;

  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        3'd0:    readdata = {30'd0, w_get_rdy, put_ready};
        3'd2:    readdata = rx_vals[rx_taken[3:0]];
        default: readdata = '0;
      endcase
    end
  end

  always @(posedge CLK) begin
    if (!RST && read && address == 3'd2) rx_taken <= rx_taken + 8'd1;
    if (!RST && write && address == 3'd1) begin
      wlog[wr_count[3:0]] <= writedata;
      wr_count            <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rx_vals[i] = '0;
    end
    // Reset and idle
    tick(); tick();
    RST = 1'b0;
    check("rst_read",   {31'd0, read}, 32'd0);
    check("rst_write",  {31'd0, write}, 32'd0);
    check("rst_addr",   {29'd0, address}, 32'd0);
    check("rst_wdata",  writedata, 32'd0);
    check("rst_txrdy",  {31'd0, tx_ready}, 32'd1);
    check("rst_rxval",  {31'd0, rx_valid}, 32'd0);
    check("rst_rxdata", rx_data, 32'd0);
    check("rst_sent",   {16'd0, flits_sent}, 32'd0);
    check("rst_rcvd",   {16'd0, flits_rcvd}, 32'd0);
    repeat (3) tick();
    check("idle_read",  {31'd0, read}, 32'd0);

    // Single write
    put_ready = 1'b1;
    push_tx(32'hDEADBEEF);
    tick();
    check("w1_poll_rd",   {31'd0, read}, 32'd1);
    check("w1_poll_addr", {29'd0, address}, 32'd0);
    tick();
    check("w1_wr",        {31'd0, write}, 32'd1);
    check("w1_wr_addr",   {29'd0, address}, 32'd1);
    check("w1_wdata",     writedata, 32'hDEADBEEF);
    check("w1_wr_noread", {31'd0, read}, 32'd0);
    tick();
    check("w1_sent",      {16'd0, flits_sent}, 32'd1);
    check("w1_wdata_0",   writedata, 32'd0);
    tick();
    check("w1_idle_rd",   {31'd0, read}, 32'd0);
    check("w1_idle_wr",   {31'd0, write}, 32'd0);

    // Single read via irq
    put_ready  = 1'b0;
    rx_vals[0] = 32'h12345678;
    rx_total   = 8'd1;
    tick();
    check("r1_poll_rd",   {31'd0, read}, 32'd1);
    check("r1_poll_addr", {29'd0, address}, 32'd0);
    tick();
    check("r1_rd",        {31'd0, read}, 32'd1);
    check("r1_rd_addr",   {29'd0, address}, 32'd2);
    tick();
    check("r1_rxval",     {31'd0, rx_valid}, 32'd1);
    check("r1_rxdata",    rx_data, 32'h12345678);
    check("r1_rcvd",      {16'd0, flits_rcvd}, 32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("r1_popped",    {31'd0, rx_valid}, 32'd0);

    // Status 3: READ precedes WRITE
    put_ready  = 1'b1;
    rx_vals[1] = 32'hBBBB0002;
    rx_total   = 8'd2;
    push_tx(32'hAAAA0001);
    check("b_poll1_addr", {28'd0, read, address}, {28'd0, 1'b1, 3'd0});
    tick();
    check("b_read_addr",  {28'd0, read, address}, {28'd0, 1'b1, 3'd2});
    tick();
    check("b_poll2_addr", {28'd0, read, address}, {28'd0, 1'b1, 3'd0});
    tick();
    check("b_write_addr", {28'd0, write, address}, {28'd0, 1'b1, 3'd1});
    check("b_wdata",      writedata, 32'hAAAA0001);
    tick();
    check("b_sent",       {16'd0, flits_sent}, 32'd2);
    check("b_rcvd",       {16'd0, flits_rcvd}, 32'd2);
    check("b_rxdata",     rx_data, 32'hBBBB0002);
    rx_ready = 1'b1;
    tick();
    rx_ready  = 1'b0;
    put_ready = 1'b0;

    // Fill RX with 6 pending flits: only 4 may be read
    for (int i = 2; i < 8; i++) begin
      rx_vals[i] = 32'h0000_0100 + i;
    end
    rx_total = 8'd8;
    repeat (30) tick();
    check("full_taken",   {24'd0, rx_taken}, 32'd6);
    check("full_rcvd",    {16'd0, flits_rcvd}, 32'd6);
    check("full_rxval",   {31'd0, rx_valid}, 32'd1);
    check("full_no_get",  {31'd0, (read && address == 3'd2)}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", rx_data, 32'h0000_0102 + i);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    repeat (10) tick();
    check("drain_wrap0",  rx_data, 32'h0000_0106);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("drain_wrap1",  rx_data, 32'h0000_0107);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("drain_empty",  {31'd0, rx_valid}, 32'd0);
    check("drain_rcvd",   {16'd0, flits_rcvd}, 32'd8);

    // Fill TX with the slave refusing writes
    for (int i = 0; i < 4; i++) begin
      push_tx(32'h0000_1000 + i);
    end
    check("txfull_rdy",   {31'd0, tx_ready}, 32'd0);
    push_tx(32'h00000BAD);
    put_ready = 1'b1;
    repeat (20) tick();
    check("tx_wr_count",  wr_count, 32'd6);
    for (int i = 0; i < 4; i++) begin
      check("tx_order", wlog[i+2], 32'h0000_1000 + i);
    end
    check("tx_sent",      {16'd0, flits_sent}, 32'd6);
    check("tx_rdy_again", {31'd0, tx_ready}, 32'd1);

    // Reset during WRITE
    push_tx(32'hCAFE0003);
    tick();
    tick();
    check("rw_write",     {31'd0, write}, 32'd1);
    check("rw_wdata",     writedata, 32'hCAFE0003);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rw_wr_drop",   {31'd0, write}, 32'd0);
    check("rw_addr",      {29'd0, address}, 32'd0);
    check("rw_wdata0",    writedata, 32'd0);
    check("rw_txrdy",     {31'd0, tx_ready}, 32'd1);
    check("rw_sent",      {16'd0, flits_sent}, 32'd0);
    check("rw_rcvd",      {16'd0, flits_rcvd}, 32'd0);
    repeat (5) tick();
    check("rw_no_write",  wr_count, 32'd6);
    check("rw_idle",      {30'd0, read, write}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flit_avalon_master.md
FLIT_AVALON_MASTER -- requirements
Module: flit_avalon_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in each of the TX and RX flit FIFOs (power of two, at least 2).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  synchronous active-high reset.
REQ-005 SHALL have port address  output  3  Avalon address to the flit slave.
REQ-006 SHALL have port read  output  1  Avalon read strobe.
REQ-007 SHALL have port write  output  1  Avalon write strobe.
REQ-008 SHALL have port writedata  output  32  flit to be sent.
REQ-009 SHALL have port readdata  input  32  slave data, zero read latency (valid in the same cycle as read).
REQ-010 SHALL have port irq  input  1  slave has a receive flit pending.
REQ-011 SHALL have port tx_data  input  32  local flit to send.
REQ-012 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-013 SHALL have port tx_ready  output  1  TX FIFO can accept a flit.
REQ-014 SHALL have port rx_data  output  32  received flit at the RX FIFO head.
REQ-015 SHALL have port rx_valid  output  1  RX FIFO is non-empty.
REQ-016 SHALL have port rx_ready  input  1  local consumer takes rx_data.
REQ-017 SHALL have port flits_sent  output  16  count of slave writes issued.
REQ-018 SHALL have port flits_rcvd  output  16  count of slave flit reads issued.

Function
REQ-019 SHALL use slave map: addr 0 = status (bit0 put-ready, bit1 get-ready), addr 1 = write flit, addr 2 = read flit.
REQ-020 SHALL implement FSM states IDLE, POLL, READ, WRITE; each non-IDLE state lasts exactly one cycle.
REQ-021 In IDLE, SHALL go to POLL next cycle if irq=1 or the TX FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-022 In POLL, SHALL drive address=0 and read=1, and SHALL sample readdata[1:0] that cycle.
REQ-023 After POLL, SHALL go to READ if bit1=1 and the RX FIFO is not full; else to WRITE if bit0=1 and the TX FIFO is non-empty; else to IDLE (READ has priority).
REQ-024 In READ, SHALL drive address=2 and read=1, push readdata into the RX FIFO that cycle, then go to POLL.
REQ-025 In WRITE, SHALL drive address=1, write=1 and writedata=TX FIFO head, pop the TX FIFO that cycle, then go to POLL.
REQ-026 SHALL never issue an addr-2 read without a preceding POLL that saw bit1=1, and never an addr-1 write without a preceding POLL that saw bit0=1.
REQ-027 SHALL decode read/write/address from the state register only; there is no combinational path from inputs to these outputs.
REQ-028 Outside READ/WRITE, SHALL hold writedata at 0; in IDLE, SHALL hold address at 0 with read=write=0.
REQ-029 SHALL set tx_ready = !TX_full from registered state; a push occurs on tx_valid && tx_ready.
REQ-030 On a full TX FIFO with a simultaneous pop, tx_ready SHALL stay 0 that cycle (no push).
REQ-031 SHALL set rx_valid = !RX_empty; a pop occurs on rx_valid && rx_ready; on an empty RX FIFO with a simultaneous push, no pop occurs.
REQ-032 SHALL deliver flits in FIFO order through both FIFOs, with pointers wrapping modulo FIFO_DEPTH.
REQ-033 SHALL increment flits_sent in each WRITE cycle and flits_rcvd in each READ cycle; both wrap 0xFFFF->0x0000.

Reset
REQ-034 While RST=1 at a clock edge: state=IDLE, read=write=0, address=0, writedata=0, FIFOs emptied (tx_ready=1, rx_valid=0, rx_data=0), counters=0.
REQ-035 Reset asserted during READ/WRITE SHALL deassert the strobe at the next edge and discard the in-flight flit.

Structure
REQ-036 Package flit_avalon_pkg SHALL hold the address constants (0/1/2), status bit indices, and the state enum.
REQ-037 SHALL contain one sub-module flit_fifo (parameter FIFO_DEPTH, 32-bit), instantiated twice, for TX and RX.

Verification
REQ-038 Reset then idle (irq=0, no tx): read=write=0, address=0, tx_ready=1, rx_valid=0, counters 0.
REQ-039 Push 0xDEADBEEF with status 0x1: POLL at addr 0, then WRITE addr 1 with writedata=0xDEADBEEF; flits_sent=1.
REQ-040 irq=1, status 0x2, readdata=0x12345678 at addr 2: READ occurs, then rx_data=0x12345678 with rx_valid=1; flits_rcvd=1.
REQ-041 Status 0x3 with TX non-empty: READ precedes WRITE; sequence POLL,READ,POLL,WRITE.
REQ-042 Fill RX (4 flits, rx_ready=0) with status 0x2 held: no 5th addr-2 read; FSM returns to IDLE/POLL.
REQ-043 Assert RST during WRITE: write=0 next cycle, TX FIFO empty, counters 0.
